// File: rtl/p_splitter.sv
// Splits a packed divider P word (remainder:quotient) into one or two
// half-word beats on a valid/ready output stream, counting delivered words.
module p_splitter #(
  parameter int HW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2*HW-1:0] p_in,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [1:0]    mode,
  output logic [HW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sel,
  output logic          out_last,
  output logic [7:0]    done_cnt,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready
  // are both high; the sender holds data stable until that edge.

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND_LO = 2'd1;
  localparam logic [1:0] S_SEND_HI = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2*HW-1:0] hold_q, hold_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      done_cnt_q, done_cnt_d;

  logic final_beat;
  logic beat_xfer;
  logic word_done;
  logic p_xfer;

  // Mode 01 finishes after the low half; 00 and 11 continue to the high half.
  assign final_beat = (state_q == S_SEND_HI) ||
                      ((state_q == S_SEND_LO) && (mode_q == 2'b01));
  assign beat_xfer  = out_valid && out_ready;
  assign word_done  = beat_xfer && final_beat;

  // Ready is gated by rst_n so it reads low while reset is held.
  assign p_ready = rst_n && ((state_q == S_IDLE) || (final_beat && out_ready));
  assign p_xfer  = p_valid && p_ready;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sel   = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      S_SEND_LO: begin
        out_valid = 1'b1;
        out_data  = hold_q[HW-1:0];
        out_sel   = 1'b0;
        out_last  = (mode_q == 2'b01);
      end
      S_SEND_HI: begin
        out_valid = 1'b1;
        out_data  = hold_q[2*HW-1:HW];
        out_sel   = 1'b1;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    mode_d     = mode_q;
    done_cnt_d = done_cnt_q + {7'd0, word_done};
    if (p_xfer) begin
      // A new word may be captured on the same edge the old one completes.
      state_d = (mode == 2'b10) ? S_SEND_HI : S_SEND_LO;
      hold_d  = p_in;
      mode_d  = mode;
    end else if (word_done) begin
      state_d = S_IDLE;
    end else if (beat_xfer && (state_q == S_SEND_LO)) begin
      state_d = S_SEND_HI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      mode_q     <= 2'b00;
      done_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      mode_q     <= mode_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt    = done_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_p_splitter.sv
// Bench for p_splitter: per-cycle vector table, then reset-mid-word and
// done_cnt wrap sequences.
module tb_p_splitter;

  logic        clk;
  logic        rst_n;
  logic [31:0] p_in;
  logic        p_valid;
  logic        p_ready;
  logic [1:0]  mode;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sel;
  logic        out_last;
  logic [7:0]  done_cnt;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  p_splitter #(.HW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p_in        (p_in),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .mode        (mode),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sel     (out_sel),
    .out_last    (out_last),
    .done_cnt    (done_cnt),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pin;
    logic [1:0]  md;
    logic        ordy;
    logic        ev;
    logic [15:0] ed;
    logic        es;
    logic        el;
    logic        epr;
    logic [7:0]  edc;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pin, input logic [1:0] md,
                       input logic ordy);
    p_valid   = pv;
    p_in      = pin;
    mode      = md;
    out_ready = ordy;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [15:0] ed,
                            input logic es, input logic el, input logic epr,
                            input logic [7:0] edc);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".out_data"},  {16'd0, out_data},  {16'd0, ed});
    chk({tag, ".out_sel"},   {31'd0, out_sel},   {31'd0, es});
    chk({tag, ".out_last"},  {31'd0, out_last},  {31'd0, el});
    chk({tag, ".p_ready"},   {31'd0, p_ready},   {31'd0, epr});
    chk({tag, ".done_cnt"},  {24'd0, done_cnt},  {24'd0, edc});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 2'b00, 1'b0);

    //        pv  p_in          md     ordy ev  data      sel  last pr   dc
    vecs[0]  = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd0};
    // basic mode 00 word
    vecs[1]  = '{1'b1, 32'h0005_0003, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[2]  = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1};
    // mode 01 then mode 10 back-to-back
    vecs[5]  = '{1'b1, 32'hAAAA_1234, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[6]  = '{1'b1, 32'h5678_BBBB, 2'b10, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b1, 1'b1, 8'd2};
    vecs[8]  = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd3};
    // stall in SEND_LO, p_in changes must be ignored
    vecs[9]  = '{1'b1, 32'h1111_2222, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd3};
    vecs[10] = '{1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[11] = '{1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[12] = '{1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[13] = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[14] = '{1'b0, 32'h0,         2'b00, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 8'd3};
    vecs[15] = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b1, 8'd3};
    // mode 11 acts as 00, then back-to-back mode 00 words with no gap
    vecs[16] = '{1'b1, 32'h00FF_FF00, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd4};
    vecs[17] = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[18] = '{1'b1, 32'h0009_0008, 2'b00, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b1, 1'b1, 8'd4};
    vecs[19] = '{1'b1, 32'h000B_000A, 2'b00, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 8'd5};
    vecs[20] = '{1'b1, 32'h000B_000A, 2'b00, 1'b1, 1'b1, 16'h0009, 1'b1, 1'b1, 1'b1, 8'd5};
    vecs[21] = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 8'd6};
    vecs[22] = '{1'b0, 32'h0,         2'b00, 1'b1, 1'b1, 16'h000B, 1'b1, 1'b1, 1'b1, 8'd6};
    vecs[23] = '{1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd7};

    // Outputs while reset is held
    #12;
    check_outs("in_reset", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: drive on negedge, sample 1ns later, edge follows
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].pv, vecs[i].pin, vecs[i].md, vecs[i].ordy);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es,
                 vecs[i].el, vecs[i].epr, vecs[i].edc);
    end

    // Reset asserted while in SEND_HI discards the word
    @(negedge clk);
    drive(1'b1, 32'h4321_8765, 2'b10, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    #1;
    check_outs("rst_pre", 1'b1, 16'h4321, 1'b1, 1'b1, 1'b0, 8'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rst_async.state", {30'd0, dbg_state}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_outs("rst_held", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("rst_release", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'd0);

    // 256 single-beat words streamed back-to-back; counter wraps to 0
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive(1'b1, {16'hFFFF, 8'd0, i[7:0]}, 2'b01, 1'b1);
      exp_q.push_back({8'd0, i[7:0]});
      #1;
      if (i > 0) begin
        chk($sformatf("wrap%0d.valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("wrap%0d.last", i), {31'd0, out_last}, 32'd1);
        if (exp_q.size() > 0)
          chk($sformatf("wrap%0d.data", i), {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        chk($sformatf("wrap%0d.cnt", i), {24'd0, done_cnt}, i - 1);
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 2'b00, 1'b1);
    #1;
    if (exp_q.size() > 0)
      chk("wrap_last.data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
    chk("wrap_last.cnt", {24'd0, done_cnt}, 32'd255);
    @(negedge clk);
    #1;
    chk("wrap_done.cnt", {24'd0, done_cnt}, 32'd0);
    chk("wrap_done.valid", {31'd0, out_valid}, 32'd0);
    chk("wrap_done.queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p_splitter.md
P_SPLITTER -- requirements
Module: p_splitter

Interface
REQ-001 Parameter HW, default 16: half-word width; packed input width is 2*HW.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 p_in  input  2*HW  packed divider P word; [HW-1:0] quotient (low), [2*HW-1:HW] remainder (high).
REQ-005 p_valid  input  1  p_in valid this cycle.
REQ-006 p_ready  output  1  block accepts p_in this cycle.
REQ-007 mode  input  2  sampled with p_in: 00 both halves (low then high), 01 low only, 10 high only, 11 treated as 00.
REQ-008 out_data  output  HW  current half-word beat.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts beat.
REQ-011 out_sel  output  1  0 = low half (quotient), 1 = high half (remainder).
REQ-012 out_last  output  1  current beat is final beat of its P word.
REQ-013 done_cnt  output  8  count of fully delivered P words, wraps 255 -> 0.

Function
REQ-014 States SHALL be IDLE, SEND_LO, SEND_HI; state, holding register, and latched mode are registered.
REQ-015 Input transfer occurs when p_valid and p_ready are both high at a rising edge; p_in is then latched into holding register and mode into mode_r.
REQ-016 p_ready SHALL be 1 in IDLE, 1 during final beat of the current word when out_ready is 1, and 0 otherwise (combinational from out_ready only).
REQ-017 On transfer, next state SHALL be SEND_HI when mode is 10, else SEND_LO; first out_valid appears the cycle after the transfer edge (latency 1).
REQ-018 SEND_LO: out_valid=1, out_data=hold[HW-1:0], out_sel=0, out_last=1 iff mode_r=01.
REQ-019 SEND_HI: out_valid=1, out_data=hold[2*HW-1:HW], out_sel=1, out_last=1.
REQ-020 IDLE: out_valid=0, out_last=0, out_sel=0, out_data=0.
REQ-021 Beat transfer occurs when out_valid and out_ready are both high at a rising edge; without it, out_data/out_sel/out_last SHALL hold stable.
REQ-022 In SEND_LO on beat transfer: mode_r 00/11 -> SEND_HI; mode_r 01 -> word complete.
REQ-023 In SEND_HI on beat transfer: word complete.
REQ-024 On word complete, done_cnt SHALL increment by 1 modulo 256; if p_valid is simultaneously high, new word is captured at the same edge and next state follows REQ-017 (no idle bubble); else next state IDLE.
REQ-025 Back-to-back words in mode 00 SHALL sustain 2 beats per word with no gap when out_ready stays 1.
REQ-026 p_in/mode changes while p_ready=0 SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, holding register 0, mode_r 00, done_cnt 0, regardless of clock.
REQ-028 During reset: out_valid=0, out_last=0, out_sel=0, out_data=0, p_ready=0.
REQ-029 Reset asserted mid-word SHALL discard the word without incrementing done_cnt; first cycle after release p_ready=1.

Verification
REQ-030 Mode 00, p_in=0x0005_0003, out_ready=1 -> beats 0x0003 (sel 0, last 0) then 0x0005 (sel 1, last 1); done_cnt 0 -> 1.
REQ-031 Mode 01 then mode 10 back-to-back, p_in=0xAAAA_1234 then 0x5678_BBBB -> single beats 0x1234 (sel 0, last 1) and 0x5678 (sel 1, last 1) on consecutive cycles; done_cnt=2.
REQ-032 Mode 00 with out_ready=0 for 3 cycles in SEND_LO -> out_data holds low half, p_ready=0, no state change; release -> normal completion.
REQ-033 Mode 11, p_in=0x00FF_FF00 -> identical to mode 00: 0xFF00 then 0x00FF.
REQ-034 Reset pulsed during SEND_HI -> outputs zero immediately, done_cnt=0, p_ready=1 first cycle after release.
REQ-035 256 single-beat words -> done_cnt wraps to 0 after the 256th.
